// File: rtl/key_load_ctrl_if.sv
// rtl/key_load_ctrl_if.sv - key-load handshake and committed key bus bundle
interface key_load_ctrl_if #(
  parameter int KEY_W = 64
);
  logic             start;
  logic             clear;
  logic             key_bit_in;
  logic             key_bit_valid;
  logic             key_bit_ready;
  logic [KEY_W-1:0] key_out;
  logic             key_valid;
  logic             busy;
  logic             error;

  modport master (
    output start, clear, key_bit_in, key_bit_valid,
    input  key_bit_ready, key_out, key_valid, busy, error
  );

  modport slave (
    input  start, clear, key_bit_in, key_bit_valid,
    output key_bit_ready, key_out, key_valid, busy, error
  );
endinterface

// File: rtl/key_load_ctrl.sv
// rtl/key_load_ctrl.sv - serial key loader with shadow register and single-cycle commit
// Optional even-parity trailer bit enabled by KEY_PARITY_CHECK_EN.
module key_load_ctrl #(
  parameter int KEY_W = 64
) (
  input logic            clk_i,
  input logic            rst_i,
  key_load_ctrl_if.slave kl_io
);
  localparam int              CNT_W    = $clog2(KEY_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(KEY_W - 1);

`ifdef KEY_PARITY_CHECK_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_PAR = 2'd2, S_CHECK = 2'd3} state_e;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_CHECK = 2'd3} state_e;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] shadow_q, shadow_d;
  logic [KEY_W-1:0] key_out_q, key_out_d;
  logic             key_valid_q, key_valid_d;
  logic             bit_ready;
  logic             bit_acc;
`ifdef KEY_PARITY_CHECK_EN
  logic             parity_q, parity_d;
  logic             error_q, error_d;
`endif

  // Ready is a pure state decode so no input reaches an output combinationally.
`ifdef KEY_PARITY_CHECK_EN
  assign bit_ready = (state_q == S_LOAD) || (state_q == S_PAR);
`else
  assign bit_ready = (state_q == S_LOAD);
`endif
  assign bit_acc = bit_ready && kl_io.key_bit_valid;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shadow_q    <= '0;
      key_out_q   <= '0;
      key_valid_q <= 1'b0;
`ifdef KEY_PARITY_CHECK_EN
      parity_q    <= 1'b0;
      error_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      key_out_q   <= key_out_d;
      key_valid_q <= key_valid_d;
`ifdef KEY_PARITY_CHECK_EN
      parity_q    <= parity_d;
      error_q     <= error_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    key_out_d   = key_out_q;
    key_valid_d = key_valid_q;
`ifdef KEY_PARITY_CHECK_EN
    parity_d    = parity_q;
    error_d     = error_q;
`endif

    if (kl_io.clear) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      shadow_d    = '0;
      key_out_d   = '0;
      key_valid_d = 1'b0;
`ifdef KEY_PARITY_CHECK_EN
      parity_d    = 1'b0;
      error_d     = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          // Starting a load revokes the old key immediately.
          if (kl_io.start) begin
            state_d     = S_LOAD;
            cnt_d       = '0;
            shadow_d    = '0;
            key_out_d   = '0;
            key_valid_d = 1'b0;
`ifdef KEY_PARITY_CHECK_EN
            error_d     = 1'b0;
`endif
          end
        end
        S_LOAD: begin
          if (bit_acc) begin
            shadow_d = {shadow_q[KEY_W-2:0], kl_io.key_bit_in};
            if (cnt_q == LAST_BIT) begin
              cnt_d = '0;
`ifdef KEY_PARITY_CHECK_EN
              state_d = S_PAR;
`else
              state_d = S_CHECK;
`endif
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
`ifdef KEY_PARITY_CHECK_EN
        S_PAR: begin
          if (bit_acc) begin
            parity_d = kl_io.key_bit_in;
            state_d  = S_CHECK;
          end
        end
`endif
        S_CHECK: begin
          state_d = S_IDLE;
`ifdef KEY_PARITY_CHECK_EN
          if (((^shadow_q) ^ parity_q) == 1'b0) begin
            key_out_d   = shadow_q;
            key_valid_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
`else
          key_out_d   = shadow_q;
          key_valid_d = 1'b1;
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign kl_io.key_bit_ready = bit_ready;
  assign kl_io.busy          = (state_q != S_IDLE);
  assign kl_io.key_out       = key_out_q;
  assign kl_io.key_valid     = key_valid_q;
`ifdef KEY_PARITY_CHECK_EN
  assign kl_io.error         = error_q;
`else
  assign kl_io.error         = 1'b0;
`endif
endmodule

// File: doc/key_load_ctrl.md
# key_load_ctrl

Serial key-load controller for the locked netlist. It accepts the locking key one bit per cycle over a valid/ready handshake and assembles it in a private shadow register. It commits the assembled key in a single cycle to the parallel key bus that drives the key inputs of the XOR/XNOR key gates. The key bus holds all-zero and `key_valid` stays low until a complete key has been loaded (and, when configured, parity-checked).

## Interface
- `KEY_W`, 64: key width in bits, minimum 2; the internal bit counter is $clog2(KEY_W) bits wide.
- `CLK` input 1: rising-edge clock.
- `RST` input 1: asynchronous, active-high reset.
- `start` input 1: begin a new key load; sampled only in IDLE.
- `clear` input 1: synchronous wipe of key and status; highest priority after `RST`.
- `key_bit_in` input 1: serial key bit, MSB first.
- `key_bit_valid` input 1: `key_bit_in` is valid this cycle.
- `key_bit_ready` output 1: controller accepts a bit this cycle.
- `key_out` output KEY_W: committed key to the key gates.
- `key_valid` output 1: `key_out` holds a completely loaded, accepted key.
- `busy` output 1: load in progress (any state other than IDLE).
- `error` output 1: last load was rejected (parity mismatch).

## Operation
- **States:** IDLE, LOAD, PAR (exists only with the macro), CHECK.
- **IDLE**
  - `key_bit_ready`=0 and `busy`=0.
  - `start`=1 moves to LOAD and, at the same edge, clears the counter, the shadow register, `key_valid` and `error`.
  - `key_out` is zeroed at that edge: the old key is revoked as soon as a new load begins.
- **LOAD**
  - `key_bit_ready`=1.
  - A bit is accepted on each edge where `key_bit_valid`=1. Shadow shifts `{shadow[KEY_W-2:0], key_bit_in}` and the counter increments.
  - When the accepted bit has counter==KEY_W-1, the next state is PAR (macro defined) or CHECK (macro undefined).
  - Cycles with `key_bit_valid`=0 stall without timeout.
- **PAR:** `key_bit_ready`=1. The next accepted bit is stored as the parity bit, and the state moves to CHECK.
- **CHECK** (one cycle, `key_bit_ready`=0)
  - If accepted: `key_out`<=shadow and `key_valid`<=1.
  - Otherwise: `error`<=1, `key_out` stays zero, `key_valid` stays 0.
  - Always returns to IDLE.
- **Ignored inputs:** `start` is ignored outside IDLE. `key_bit_valid` is ignored while `key_bit_ready`=0.
- **clear:** in any state, sets `key_out`=0, `key_valid`=0, `error`=0, counter=0, shadow=0, state=IDLE. It overrides `start` and bit acceptance in the same cycle.
- **Reset values:** `RST` asynchronously forces `key_out`=0, `key_valid`=0, `error`=0, `busy`=0, `key_bit_ready`=0, state=IDLE. Reset mid-load discards the partial key.
- **Registered outputs:** all outputs are registered or decoded from state only, with no combinational path from inputs to outputs.

## Timing
- **Outputs after start:** `start` sampled at edge E0 (IDLE) gives `busy`=1 and `key_bit_ready`=1 from E0 onward.
- **Minimum load length:** KEY_W accepted bits (KEY_W+1 with the macro), with valid held high, end at edge E0+KEY_W (+1).
- **Commit:** CHECK occupies the next cycle. `key_valid`/`error` update at the following edge, so `key_valid` rises KEY_W+1 (+1) edges after E0.
- **Back-to-back loads:** `start` may be asserted in the first IDLE cycle after CHECK.
- **Key stability:** `key_out` changes only at commit, clear, start-from-IDLE, or reset.

## Configuration
- `KEY_PARITY_CHECK_EN` defined:
  - PAR state exists and one extra bit follows the key.
  - CHECK accepts only if (^shadow) ^ parity_bit == 0 (even parity); otherwise it flags `error`.
- `KEY_PARITY_CHECK_EN` undefined:
  - PAR is not built and LOAD goes directly to CHECK.
  - CHECK always accepts, and `error` is tied to 0.

## Test plan
- **Reset:** assert `RST` mid-LOAD after 10 bits → all outputs 0 immediately; a subsequent full load of KEY_W=64 bits 0xA5A5_0F0F_1234_5678 → `key_out`=0xA5A5_0F0F_1234_5678 and `key_valid`=1 exactly 65 edges after the `start` edge (no macro).
- **Stalls:** same key with `key_bit_valid` toggling 1/0 every cycle → identical `key_out`, `key_valid` 129 edges after start. `key_bit_in` driven with garbage during valid=0 cycles has no effect.
- **Parity (macro on):**
  - key 0x0000_0000_0000_0001 with parity bit 1 → `key_valid`=1, `error`=0.
  - Same key with parity bit 0 → `error`=1, `key_valid`=0, `key_out`=0.
- **start during LOAD:** pulse `start` at bit 30 → ignored; load completes with the correct key. Then `start` in IDLE → `key_valid` and `key_out` drop to 0 at that edge.
- **clear:** assert `clear` in the same cycle as the final key bit → state IDLE, `key_valid`=0, `key_out`=0, and no commit occurs the next cycle.
- **Minimum width:** KEY_W=2, bits 1,0 → `key_out`=2'b10 and `key_valid`=1 three edges after start (no macro).
